// File: rtl/mac_pkg.sv
// mac_pkg: default widths, controller states and response record shared by the MAC arbiter files
package mac_pkg;
  localparam int W_DEF = 8;
  localparam int N_REQ_DEF = 4;
  localparam int ID_W = $clog2(N_REQ_DEF);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [W_DEF-1:0] data;
    logic             ovf;
  } rsp_t;
endpackage

// File: rtl/mac_unit.sv
// mac_unit: combinational unsigned a*b + c returning the low W bits and an overflow flag
// ports: i_a/i_b/i_c operands, o_res low W bits of the sum, o_ovf set when the sum needs more than W bits
module mac_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_res,
  output logic         o_ovf
);
  logic [2*W-1:0] w_prod;
  logic [2*W:0]   w_sum;
  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  assign w_sum  = {1'b0, w_prod} + {{(W+1){1'b0}}, i_c};
  assign o_res  = w_sum[W-1:0];
  assign o_ovf  = |w_sum[2*W:W];
endmodule

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one multiply-add unit among N_REQ valid/ready requesters
// ports: clock/reset_n (async active-low); req_valid/req_ready and req_a/b/c per requester;
//        rsp_valid/rsp_ready response handshake carrying rsp_id, rsp_data, rsp_ovf; busy when not IDLE
module mac_share_arbiter
  import mac_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ-1:0][W-1:0]           req_a,
  input  logic [N_REQ-1:0][W-1:0]           req_b,
  input  logic [N_REQ-1:0][W-1:0]           req_c,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(N_REQ)-1:0]          rsp_id,
  output logic [W-1:0]                      rsp_data,
  output logic                              rsp_ovf,
  output logic                              busy
);
  localparam int IW = $clog2(N_REQ);
  state_t          r_state, w_next;
  logic [IW-1:0]   r_last, w_gnt, w_idx;
  logic [W-1:0]    r_a, r_b, r_c, r_rsp_data, w_res;
  logic            r_rsp_valid, r_rsp_ovf, w_ovf, w_found, w_take;
  logic [IW-1:0]   r_rsp_id;
  logic [N_REQ-1:0] w_onehot;
  mac_unit #(.W(W)) u_mac (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_c  (r_c),
    .o_res(w_res),
    .o_ovf(w_ovf)
  );
  // Scan offsets from N_REQ down to 1 so the nearest requester after r_last wins;
  // offset N_REQ wraps to r_last itself, giving it lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = r_last + IW'(i);
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end
  // Gating with reset_n keeps req_ready low while reset is held.
  assign w_take   = w_found & reset_n;
  assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_gnt;
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      IDLE: if (w_take) begin
        req_ready = w_onehot;
        w_next    = CALC;
      end
      CALC: w_next = HOLD;
      HOLD: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last      <= IW'(N_REQ - 1);
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_take) begin
        r_last <= w_gnt;
        r_a    <= req_a[w_gnt];
        r_b    <= req_b[w_gnt];
        r_c    <= req_c[w_gnt];
      end
      if (r_state == CALC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_last;
        r_rsp_data  <= w_res;
        r_rsp_ovf   <= w_ovf;
      end
      if (r_state == HOLD && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_ovf   = r_rsp_ovf;
  assign busy      = r_state != IDLE;
endmodule

// File: doc/mac_share_arbiter.md
# mac_share_arbiter

Shares a single multiply-add datapath (out = A·B + C, low W bits) among N_REQ independent requesters. Each requester presents an operand triple with a valid/ready handshake. A round-robin arbiter grants one requester at a time and sequences the datapath through a three-state controller. The result returns on a common response channel tagged with the requester ID. It sits between the per-channel front-ends and the shared arithmetic unit, replacing free-running counter-driven sequencing with handshake-driven scheduling.

## Interface
Parameters:
- N_REQ, default 4: number of requesters (power of two, ≥2).
- W, default 8: operand and result width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a, req_b, req_c  in  N_REQ×W each  per-requester operands.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns the response.
- rsp_data  out  W  (a·b + c) mod 2^W.
- rsp_ovf  out  1  set when the full-precision a·b + c ≥ 2^W.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, CALC and HOLD.
- **IDLE**
  - If any req_valid is high, the arbiter picks the winner g: the first requester with valid set, searching from last_grant+1 upward and wrapping modulo N_REQ.
  - req_ready[g] is driven combinationally high in the same cycle. The handshake completes on that edge.
  - On that edge the controller latches a/b/c of g into the operand registers, sets last_grant ← g and goes to CALC.
  - With no valid request, req_ready is all zero and the FSM stays in IDLE.
- **CALC**
  - The sub-module computes the product and sum combinationally from the operand registers.
  - On the next edge, rsp_data, rsp_ovf and rsp_id ← g are registered, rsp_valid ← 1, and the FSM goes to HOLD.
- **HOLD**
  - rsp_valid, rsp_id, rsp_data and rsp_ovf stay stable until rsp_valid && rsp_ready.
  - On that edge, rsp_valid ← 0 and the FSM goes to IDLE.
- **Arithmetic**
  - The product is 2W bits and the sum 2W+1 bits, all unsigned.
  - rsp_data takes the low W bits; rsp_ovf is the OR of bits [2W:W].
- **Boundary conditions**
  - req_ready is never high outside IDLE, so requests in CALC or HOLD wait.
  - A requester may drop req_valid before it is granted; it is then simply skipped.
  - After a grant to requester N_REQ-1, the search wraps to requester 0.
  - The priority pointer advances only on a completed handshake.
  - If rsp_ready stays low, the FSM stays in HOLD indefinitely and no new grants are made.
  - Reset asserted mid-operation aborts the operation: the in-flight operation is discarded, no response is issued, and all state returns to reset values immediately.

## Timing
- **Reset values:** state = IDLE, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_ovf = 0, busy = 0. last_grant = N_REQ-1, so requester 0 has first priority.
- **Latency:**
  - Handshake on edge E0.
  - rsp_valid is high from E1.
  - With rsp_ready held high, the response is consumed on E2 and the FSM is in IDLE after E2.
  - The next handshake is possible on E3.
- **Throughput:** one operation per 3 cycles with no backpressure.
- **Handshake paths:**
  - req_ready depends combinationally on req_valid and state. There is no combinational path from rsp_ready to req_ready.
  - rsp_* outputs are registered.

## Structure
- **Package mac_pkg:**
  - W and N_REQ defaults.
  - ID_W = $clog2(N_REQ).
  - State enum typedef: IDLE, CALC, HOLD.
  - Response struct typedef: id, data, ovf.
- **Sub-module mac_unit:** purely combinational a·b + c. It outputs the low-W result and the ovf flag.
- **Top level:** FSM, round-robin arbiter (rotate-priority-encode) and output registers live in mac_share_arbiter.

## Test plan
- **Single request:** requester 2 presents a=3, b=4, c=5 → req_ready[2] high that cycle; rsp_valid one edge later with rsp_id=2, rsp_data=0x11, rsp_ovf=0.
- **Simultaneous requests:** all four valid from reset with rsp_ready=1 → responses in order ID 0,1,2,3, each 3 cycles apart. No req_ready ever asserted outside IDLE.
- **Wrap-around fairness:** after a grant to 3, requesters 0 and 3 are both valid → 0 is granted first, then 3.
- **Overflow:**
  - a=255, b=255, c=255 → rsp_data=0x00, rsp_ovf=1.
  - a=15, b=16, c=15 → rsp_data=0xFF, rsp_ovf=0.
- **Backpressure:** rsp_ready held low for 10 cycles with another requester valid → rsp_* stable, busy=1, no req_ready. After release, the next grant occurs 1 cycle after the consume edge.
- **Reset mid-operation:** assert reset_n=0 during CALC → all outputs return to reset values asynchronously. No response appears after release, and the first grant after reset goes to requester 0.
